// File: rtl/token_buffer_arb.sv
// Burst arbiter/sequencer sharing the single-port token SRAM among four requesters.
// Define TOKEN_BUF_ARB_FIXED_PRIO_EN for fixed priority Collector > Gating > Dispatcher > DRAM.
module token_buffer_arb #(
    parameter int NSRC = 4,
    parameter int AW   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_dram_req,
    input  logic [AW-1:0]            i_dram_base,
    input  logic [AW-1:0]            i_dram_len,
    input  logic                     i_dram_we,
    input  logic                     i_disp_req,
    input  logic [AW-1:0]            i_disp_base,
    input  logic [AW-1:0]            i_disp_len,
    input  logic                     i_col_req,
    input  logic [AW-1:0]            i_col_base,
    input  logic [AW-1:0]            i_col_len,
    input  logic                     i_gate_req,
    input  logic [AW-1:0]            i_gate_base,
    input  logic [AW-1:0]            i_gate_len,
    input  logic                     i_gate_we,
    output logic                     o_dram_gnt,
    output logic                     o_dram_beat,
    output logic                     o_dram_done,
    output logic                     o_disp_gnt,
    output logic                     o_disp_beat,
    output logic                     o_disp_done,
    output logic                     o_col_gnt,
    output logic                     o_col_beat,
    output logic                     o_col_done,
    output logic                     o_gate_gnt,
    output logic                     o_gate_beat,
    output logic                     o_gate_done,
    output logic [$clog2(NSRC)-1:0]  o_tb_src_sel,
    output logic                     o_tb_dram_req,
    output logic                     o_tb_disp_req,
    output logic                     o_tb_col_req,
    output logic                     o_tb_gate_req,
    output logic [AW-1:0]            o_tb_dram_addr,
    output logic [AW-1:0]            o_tb_disp_addr,
    output logic [AW-1:0]            o_tb_col_addr,
    output logic [AW-1:0]            o_tb_gate_addr,
    output logic                     o_tb_dram_we,
    output logic                     o_tb_gate_we
);

    localparam int SW = $clog2(NSRC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_DRAIN
    } state_t;

    state_t            r_state, w_state_n;
    logic [SW-1:0]     r_src, w_src_n;
    logic [NSRC-1:0]   r_gnt, w_gnt_n;
    logic [NSRC-1:0]   r_beat, w_beat_n;
    logic [NSRC-1:0]   r_done, w_done_n;
    logic [NSRC-1:0]   r_treq, w_treq_n;
    logic [AW-1:0]     r_addr [NSRC];
    logic [AW-1:0]     w_addr_n [NSRC];
    logic              r_dwe, w_dwe_n;
    logic              r_gwe, w_gwe_n;
    logic [AW-1:0]     r_base, w_base_n;
    logic [AW-1:0]     r_len, w_len_n;
    logic [AW-1:0]     r_cnt, w_cnt_n;
    logic              r_drn, w_drn_n;

    logic [NSRC-1:0]   w_req;
    logic [AW-1:0]     w_base [NSRC];
    logic [AW-1:0]     w_len [NSRC];
    logic              w_found;
    logic [SW-1:0]     w_win;
    logic [NSRC-1:0]   w_win_oh;
    logic [AW-1:0]     w_nxt_cnt;
    logic [AW-1:0]     w_nxt_addr;

    assign w_req     = {i_gate_req, i_col_req, i_disp_req, i_dram_req};
    assign w_base[0] = i_dram_base;
    assign w_base[1] = i_disp_base;
    assign w_base[2] = i_col_base;
    assign w_base[3] = i_gate_base;
    assign w_len[0]  = i_dram_len;
    assign w_len[1]  = i_disp_len;
    assign w_len[2]  = i_col_len;
    assign w_len[3]  = i_gate_len;

    assign w_win_oh   = NSRC'(1) << w_win;
    assign w_nxt_cnt  = r_cnt + AW'(1);
    assign w_nxt_addr = r_base + w_nxt_cnt;

`ifdef TOKEN_BUF_ARB_FIXED_PRIO_EN
    always_comb begin
        w_found = |w_req;
        w_win   = '0;
        if (w_req[2])      w_win = SW'(2);
        else if (w_req[3]) w_win = SW'(3);
        else if (w_req[1]) w_win = SW'(1);
        else               w_win = SW'(0);
    end
`else
    logic [SW-1:0] r_rr;
    logic [SW-1:0] w_idx;

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 0; i < NSRC; i++) begin
            w_idx = r_rr + SW'(i);
            if (!w_found && w_req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_rr <= '0;
        else if (r_state == S_IDLE && w_found)
            r_rr <= w_win + SW'(1);
    end
`endif

    always_comb begin
        w_state_n = r_state;
        w_src_n   = r_src;
        w_gnt_n   = r_gnt;
        w_beat_n  = r_beat;
        w_done_n  = '0;
        w_treq_n  = r_treq;
        w_addr_n  = r_addr;
        w_dwe_n   = r_dwe;
        w_gwe_n   = r_gwe;
        w_base_n  = r_base;
        w_len_n   = r_len;
        w_cnt_n   = r_cnt;
        w_drn_n   = r_drn;
        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_n       = S_BURST;
                    w_src_n         = w_win;
                    w_gnt_n         = w_win_oh;
                    w_beat_n        = w_win_oh;
                    w_treq_n        = w_win_oh;
                    w_addr_n[w_win] = w_base[w_win];
                    w_base_n        = w_base[w_win];
                    w_len_n         = w_len[w_win];
                    w_cnt_n         = '0;
                    w_dwe_n         = (w_win == SW'(0)) && i_dram_we;
                    w_gwe_n         = (w_win == SW'(3)) && i_gate_we;
                end
            end
            S_BURST: begin
                if (r_cnt == r_len) begin
                    w_state_n = S_DRAIN;
                    w_beat_n  = '0;
                    w_treq_n  = '0;
                    w_dwe_n   = 1'b0;
                    w_gwe_n   = 1'b0;
                    w_drn_n   = 1'b0;
                end else begin
                    w_cnt_n         = w_nxt_cnt;
                    w_addr_n[r_src] = w_nxt_addr;
                end
            end
            S_DRAIN: begin
                // Done lands on the buffer's last read-data cycle.
                if (!r_drn) begin
                    w_drn_n  = 1'b1;
                    w_done_n = r_gnt;
                end else begin
                    w_state_n = S_IDLE;
                    w_gnt_n   = '0;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_src   <= '0;
            r_gnt   <= '0;
            r_beat  <= '0;
            r_done  <= '0;
            r_treq  <= '0;
            for (int i = 0; i < NSRC; i++) r_addr[i] <= '0;
            r_dwe   <= 1'b0;
            r_gwe   <= 1'b0;
            r_base  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_drn   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_src   <= w_src_n;
            r_gnt   <= w_gnt_n;
            r_beat  <= w_beat_n;
            r_done  <= w_done_n;
            r_treq  <= w_treq_n;
            r_addr  <= w_addr_n;
            r_dwe   <= w_dwe_n;
            r_gwe   <= w_gwe_n;
            r_base  <= w_base_n;
            r_len   <= w_len_n;
            r_cnt   <= w_cnt_n;
            r_drn   <= w_drn_n;
        end
    end

    assign o_tb_src_sel   = r_src;
    assign o_dram_gnt     = r_gnt[0];
    assign o_disp_gnt     = r_gnt[1];
    assign o_col_gnt      = r_gnt[2];
    assign o_gate_gnt     = r_gnt[3];
    assign o_dram_beat    = r_beat[0];
    assign o_disp_beat    = r_beat[1];
    assign o_col_beat     = r_beat[2];
    assign o_gate_beat    = r_beat[3];
    assign o_dram_done    = r_done[0];
    assign o_disp_done    = r_done[1];
    assign o_col_done     = r_done[2];
    assign o_gate_done    = r_done[3];
    assign o_tb_dram_req  = r_treq[0];
    assign o_tb_disp_req  = r_treq[1];
    assign o_tb_col_req   = r_treq[2];
    assign o_tb_gate_req  = r_treq[3];
    assign o_tb_dram_addr = r_addr[0];
    assign o_tb_disp_addr = r_addr[1];
    assign o_tb_col_addr  = r_addr[2];
    assign o_tb_gate_addr = r_addr[3];
    assign o_tb_dram_we   = r_dwe;
    assign o_tb_gate_we   = r_gwe;

endmodule

// File: tb/tb_token_buffer_arb.sv
// Self-checking bench for token_buffer_arb: directed burst table plus corner sequences.
module tb_token_buffer_arb;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [7:0] base [4];
    logic [7:0] len [4];
    logic       dram_we = 1'b0;
    logic       gate_we = 1'b0;

    logic o_dram_gnt, o_dram_beat, o_dram_done;
    logic o_disp_gnt, o_disp_beat, o_disp_done;
    logic o_col_gnt, o_col_beat, o_col_done;
    logic o_gate_gnt, o_gate_beat, o_gate_done;
    logic [1:0] sel;
    logic o_tb_dram_req, o_tb_disp_req, o_tb_col_req, o_tb_gate_req;
    logic [7:0] o_tb_dram_addr, o_tb_disp_addr, o_tb_col_addr, o_tb_gate_addr;
    logic o_tb_dram_we, o_tb_gate_we;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    token_buffer_arb #(.NSRC(4), .AW(8)) dut (
        .clk(clk), .rst(rst),
        .i_dram_req(req[0]), .i_dram_base(base[0]), .i_dram_len(len[0]), .i_dram_we(dram_we),
        .i_disp_req(req[1]), .i_disp_base(base[1]), .i_disp_len(len[1]),
        .i_col_req(req[2]), .i_col_base(base[2]), .i_col_len(len[2]),
        .i_gate_req(req[3]), .i_gate_base(base[3]), .i_gate_len(len[3]), .i_gate_we(gate_we),
        .o_dram_gnt(o_dram_gnt), .o_dram_beat(o_dram_beat), .o_dram_done(o_dram_done),
        .o_disp_gnt(o_disp_gnt), .o_disp_beat(o_disp_beat), .o_disp_done(o_disp_done),
        .o_col_gnt(o_col_gnt), .o_col_beat(o_col_beat), .o_col_done(o_col_done),
        .o_gate_gnt(o_gate_gnt), .o_gate_beat(o_gate_beat), .o_gate_done(o_gate_done),
        .o_tb_src_sel(sel),
        .o_tb_dram_req(o_tb_dram_req), .o_tb_disp_req(o_tb_disp_req),
        .o_tb_col_req(o_tb_col_req), .o_tb_gate_req(o_tb_gate_req),
        .o_tb_dram_addr(o_tb_dram_addr), .o_tb_disp_addr(o_tb_disp_addr),
        .o_tb_col_addr(o_tb_col_addr), .o_tb_gate_addr(o_tb_gate_addr),
        .o_tb_dram_we(o_tb_dram_we), .o_tb_gate_we(o_tb_gate_we)
    );

    logic [3:0] g, b, d, q;
    logic [1:0] we2;
    logic [7:0] a [4];
    assign g   = {o_gate_gnt, o_col_gnt, o_disp_gnt, o_dram_gnt};
    assign b   = {o_gate_beat, o_col_beat, o_disp_beat, o_dram_beat};
    assign d   = {o_gate_done, o_col_done, o_disp_done, o_dram_done};
    assign q   = {o_tb_gate_req, o_tb_col_req, o_tb_disp_req, o_tb_dram_req};
    assign we2 = {o_tb_gate_we, o_tb_dram_we};
    assign a[0] = o_tb_dram_addr;
    assign a[1] = o_tb_disp_addr;
    assign a[2] = o_tb_col_addr;
    assign a[3] = o_tb_gate_addr;

    typedef struct {
        int         src;
        logic [7:0] base;
        logic [7:0] len;
        logic       we;
        logic [7:0] exp_first;
        logic [7:0] exp_last;
        logic [1:0] exp_we;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_gnt"}, {28'd0, g}, 32'd0);
        chk({nm, "_beat"}, {28'd0, b}, 32'd0);
        chk({nm, "_done"}, {28'd0, d}, 32'd0);
        chk({nm, "_treq"}, {28'd0, q}, 32'd0);
        chk({nm, "_we"}, {30'd0, we2}, 32'd0);
        chk({nm, "_sel"}, {30'd0, sel}, 32'd0);
        chk({nm, "_addr"}, {a[3], a[2], a[1], a[0]}, 32'd0);
    endtask

    initial begin
        logic [3:0] oh;
        int         order [4];
        int         n;
        for (int i = 0; i < 4; i++) begin
            base[i] = '0;
            len[i]  = '0;
        end
        vt[0] = '{0, 8'h10, 8'd0, 1'b1, 8'h10, 8'h10, 2'b01};
        vt[1] = '{1, 8'hFE, 8'd3, 1'b0, 8'hFE, 8'h01, 2'b00};
        vt[2] = '{2, 8'h80, 8'd2, 1'b0, 8'h80, 8'h82, 2'b00};
        vt[3] = '{3, 8'hFF, 8'd1, 1'b1, 8'hFF, 8'h00, 2'b10};
        vt[4] = '{0, 8'hF0, 8'd4, 1'b0, 8'hF0, 8'hF4, 2'b00};
        vt[5] = '{3, 8'h30, 8'd0, 1'b0, 8'h30, 8'h30, 2'b00};

        tick();
        chk_all_zero("reset");
        rst = 1'b0;

        // All four requesting from reset, len=0 each.
`ifdef TOKEN_BUF_ARB_FIXED_PRIO_EN
        order = '{2, 3, 1, 0};
`else
        order = '{0, 1, 2, 3};
`endif
        for (int i = 0; i < 4; i++) begin
            base[i] = 8'(i * 16);
            len[i]  = 8'd0;
        end
        req = 4'hF;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("all4_gnt", {28'd0, g}, 32'(1 << order[i]));
            chk("all4_sel", {30'd0, sel}, 32'(order[i]));
            req[order[i]] = 1'b0;
            tick();
            tick();
            tick();
        end

        // Table of single bursts, back to back from IDLE.
        for (int e = 0; e < 6; e++) begin
            oh = 4'(1 << vt[e].src);
            base[vt[e].src] = vt[e].base;
            len[vt[e].src]  = vt[e].len;
            if (vt[e].src == 0) dram_we = vt[e].we;
            if (vt[e].src == 3) gate_we = vt[e].we;
            req[vt[e].src] = 1'b1;
            n = int'(vt[e].len) + 1;
            for (int k = 0; k < n; k++) begin
                tick();
                chk("tbl_gnt", {28'd0, g}, {28'd0, oh});
                chk("tbl_beat", {28'd0, b}, {28'd0, oh});
                chk("tbl_treq", {28'd0, q}, {28'd0, oh});
                chk("tbl_sel", {30'd0, sel}, 32'(vt[e].src));
                chk("tbl_we", {30'd0, we2}, {30'd0, vt[e].exp_we});
                chk("tbl_done_early", {28'd0, d}, 32'd0);
                if (k == 0)
                    chk("tbl_addr_first", {24'd0, a[vt[e].src]}, {24'd0, vt[e].exp_first});
                else if (k == n - 1)
                    chk("tbl_addr_last", {24'd0, a[vt[e].src]}, {24'd0, vt[e].exp_last});
                else
                    chk("tbl_addr_mid", {24'd0, a[vt[e].src]}, {24'd0, 8'(vt[e].base + 8'(k))});
                if (k == 0) req[vt[e].src] = 1'b0;
            end
            tick();
            chk("tbl_drain1_treq", {28'd0, q}, 32'd0);
            chk("tbl_drain1_gnt", {28'd0, g}, {28'd0, oh});
            chk("tbl_drain1_done", {28'd0, d}, 32'd0);
            tick();
            chk("tbl_drain2_done", {28'd0, d}, {28'd0, oh});
            chk("tbl_drain2_sel", {30'd0, sel}, 32'(vt[e].src));
            tick();
            chk("tbl_idle_gnt", {28'd0, g}, 32'd0);
            chk("tbl_idle_done", {28'd0, d}, 32'd0);
        end
        dram_we = 1'b0;
        gate_we = 1'b0;

        // Reset mid-burst: dram write len=7, rst during beat 3.
        base[0] = 8'h20;
        len[0]  = 8'd7;
        dram_we = 1'b1;
        req[0]  = 1'b1;
        tick();
        req[0] = 1'b0;
        tick();
        tick();
        tick();
        chk("rst_pre_addr", {24'd0, a[0]}, 32'h23);
        chk("rst_pre_we", {30'd0, we2}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("rst_async");
        tick();
        tick();
        rst = 1'b0;
        dram_we = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("rst_after_done", {28'd0, d}, 32'd0);
            chk("rst_after_gnt", {28'd0, g}, 32'd0);
        end

        // Fairness between col and gate, from a fresh reset.
        do_reset();
        base[2] = 8'h50;
        base[3] = 8'h60;
        len[2]  = 8'd0;
        len[3]  = 8'd0;
        req[2]  = 1'b1;
        req[3]  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
`ifdef TOKEN_BUF_ARB_FIXED_PRIO_EN
            chk("fair_gnt", {28'd0, g}, 32'h4);
`else
            chk("fair_gnt", {28'd0, g}, (i % 2 == 0) ? 32'h4 : 32'h8);
`endif
            tick();
            tick();
            tick();
        end
        req = '0;
        tick();
        tick();

        // Gate read with base/we/len changed mid-burst.
        base[3] = 8'h40;
        len[3]  = 8'd2;
        gate_we = 1'b0;
        req[3]  = 1'b1;
        tick();
        chk("chg_addr0", {24'd0, a[3]}, 32'h40);
        chk("chg_sel0", {30'd0, sel}, 32'd3);
        req[3]  = 1'b0;
        base[3] = 8'h99;
        len[3]  = 8'd9;
        gate_we = 1'b1;
        tick();
        chk("chg_addr1", {24'd0, a[3]}, 32'h41);
        chk("chg_we1", {30'd0, we2}, 32'd0);
        tick();
        chk("chg_addr2", {24'd0, a[3]}, 32'h42);
        chk("chg_we2", {30'd0, we2}, 32'd0);
        chk("chg_beat2", {28'd0, b}, 32'h8);
        tick();
        chk("chg_drain1_treq", {28'd0, q}, 32'd0);
        chk("chg_drain1_sel", {30'd0, sel}, 32'd3);
        tick();
        chk("chg_done", {28'd0, d}, 32'h8);
        chk("chg_drain2_sel", {30'd0, sel}, 32'd3);
        tick();
        chk("chg_idle_gnt", {28'd0, g}, 32'd0);
        chk("chg_idle_done", {28'd0, d}, 32'd0);
        gate_we = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/token_buffer_arb.md
# token_buffer_arb

Burst-level arbiter and sequencer in front of the token buffer. It shares the single-port token SRAM between four requesters: DRAM loader, Dispatcher, Collector and Gating. It grants one requester at a time and drives the buffer's source select and per-port request/address lines for a whole burst. It then holds the grant until the buffer's two-stage pipeline has drained, and signals burst completion.

## Interface
Parameters:
- NSRC, 4, number of requesters; fixed encoding 0=DRAM, 1=Dispatcher, 2=Collector, 3=Gating (matches buffer src_sel)
- AW, 8, token buffer address width

Ports (X ∈ {dram, disp, col, gate}):
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- X_req  input  1  burst request, level; held until X_gnt
- X_base  input  AW  first beat address, sampled at grant
- X_len  input  AW  beats minus one (0..255), sampled at grant
- dram_we, gate_we  input  1  1=write burst, 0=read burst, sampled at grant; disp always reads, col always writes
- X_gnt  output  1  high from first beat through last drain cycle
- X_beat  output  1  high in each cycle a beat is issued; requester presents write data that cycle
- X_done  output  1  one-cycle pulse when burst fully retired
- tb_src_sel  output  2  to buffer in_src_sel
- tb_X_req  output  1  to buffer in_X_req
- tb_X_addr  output  AW  to buffer in_X_addr
- tb_dram_we, tb_gate_we  output  1  to buffer write enables

## Operation
- FSM states: IDLE, BURST, DRAIN. Reset → IDLE.
- IDLE: if any X_req is high, select a winner. Default is round-robin starting at rr_ptr. At the clock edge: BURST, tb_src_sel<=winner, X_gnt<=1, latch base/len/we, beat_cnt<=0, rr_ptr<=winner+1 (mod 4). If no request, stay in IDLE; tb_src_sel holds its last value.
- BURST: each cycle, drive tb_X_req=1 and tb_X_addr=(base+beat_cnt) mod 2^AW. Address wraps 255→0. Set tb_*_we to the latched we and X_beat=1. All non-granted tb_*_req are 0. At beat_cnt==len the next state is DRAIN.
- DRAIN: exactly 2 cycles. All tb_*_req=0, tb_src_sel held, X_gnt held. X_done pulses in the 2nd drain cycle, which aligns with the buffer's last out_X_rdata_valid for reads. Next state is IDLE.
- Requests are sampled only in IDLE. Changes to X_req, X_base, X_len or X_we during a burst are ignored; the burst always completes all len+1 beats.
- Simultaneous requests: exactly one grant. Losers stay pending and keep X_req high.
- Only one X_gnt is ever high at a time. tb_src_sel never changes while any X_gnt is high.

## Timing
- All outputs are registered.
- Reset values: state=IDLE, rr_ptr=0, tb_src_sel=0. All X_gnt, X_beat, X_done, tb_*_req, tb_*_we are 0; all tb_*_addr are 0.
- Request sampled high in IDLE at cycle C → first beat on tb ports in cycle C+1.
- Burst of N=len+1 beats occupies cycles C+1..C+N; drain occupies C+N+1..C+N+2; X_done is at C+N+2; IDLE at C+N+3.
- Occupancy per burst: N+3 cycles including the arbitration cycle. No back-to-back burst skips IDLE.
- Read data for beat k appears on buffer out_X_rdata two cycles after the X_beat cycle of beat k.
- rst asserted mid-burst: immediate return to reset values. No X_done is issued for the aborted burst.

## Configuration
- TOKEN_BUF_ARB_FIXED_PRIO_EN defined: fixed priority Collector > Gating > Dispatcher > DRAM; rr_ptr is not implemented.
- Not defined: round-robin as described; rr_ptr advances to winner+1 on each grant.

## Test plan
- Reset mid-burst: dram write len=7 is active; assert rst on beat 3 → all outputs 0 asynchronously. After release, IDLE; no dram_done.
- Single DRAM write: dram_req=1, base=0x10, len=0, we=1 at C → tb_src_sel=0, tb_dram_req=1, addr=0x10, dram_beat at C+1; dram_done at C+3; IDLE at C+4.
- Dispatcher read with wrap: base=0xFE, len=3 → addresses FE, FF, 00, 01 in 4 consecutive cycles. disp_done coincides with the 4th out_disp_rdata_valid.
- All four requesting from reset, len=0 each → grants in order dram, disp, col, gate, each 4 cycles apart. With TOKEN_BUF_ARB_FIXED_PRIO_EN the order is col, gate, disp, dram.
- Fairness: col and gate continuously requesting → grants alternate col, gate, col…. Neither starves.
- Input change during burst: gate read len=2; toggle gate_base and gate_we mid-burst → addresses unchanged, no write issued, tb_src_sel stays 3 until after gate_done.
